// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the parametrised FIFO.
package fifo_pkg;

    localparam int DEF_DEPTH     = 64;
    localparam int DEF_AE_LEVEL  = 4;
    localparam int DEF_AF_MARGIN = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_dp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable thresholds, sticky error flags
// and optional first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        buf_in,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        buf_out,
    output logic                     buf_empty,
    output logic                     buf_full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  fifo_counter,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 4 || AE_LEVEL >= AF_LEVEL
        || AF_LEVEL > DEPTH) begin : g_bad_cfg
        $fatal(1, "sync_fifo_param: illegal DEPTH/threshold setting");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] out_q;
    logic              wr_acc;
    logic              rd_acc;

    assign buf_empty    = (count == '0);
    assign buf_full     = (count == FULL_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign fifo_counter = count;

    assign wr_acc = wr_en && !buf_full;
    assign rd_acc = rd_en && !buf_empty;

    fifo_dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (buf_in),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // out_q is the read register in normal mode and the
            // last-popped hold value in fall-through mode.
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                out_q  <= ram_q;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= (overflow && !clr_err) || (wr_en && buf_full);
            underflow <= (underflow && !clr_err) || (rd_en && buf_empty);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign buf_out = buf_empty ? out_q : ram_q;
    end else begin : g_reg
        assign buf_out = out_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: one registered-read and one fall-through instance
// driven by the same stimulus and checked against a queue model.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;
    localparam int CW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic          clr_err;
    logic [DW-1:0] buf_in;

    logic [DW-1:0] out0, out1;
    logic          empty0, empty1, full0, full1;
    logic          af0, af1, ae0, ae1;
    logic [CW-1:0] cnt0, cnt1;
    logic          ovf0, ovf1, udf0, udf1;

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF),
        .AE_LEVEL(AE), .FWFT(0)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in),
        .rd_en(rd_en), .buf_out(out0), .buf_empty(empty0),
        .buf_full(full0), .almost_full(af0), .almost_empty(ae0),
        .fifo_counter(cnt0), .overflow(ovf0), .underflow(udf0),
        .clr_err(clr_err)
    );

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF),
        .AE_LEVEL(AE), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in),
        .rd_en(rd_en), .buf_out(out1), .buf_empty(empty1),
        .buf_full(full1), .almost_full(af1), .almost_empty(ae1),
        .fifo_counter(cnt1), .overflow(ovf1), .underflow(udf1),
        .clr_err(clr_err)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_pop;
    logic          m_ovf;
    logic          m_udf;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        int head;
        n    = mq.size();
        head = (n != 0) ? int'(mq[0]) : int'(last_pop);
        chk("count0", cnt0, n);
        chk("count1", cnt1, n);
        chk("empty0", empty0, int'(n == 0));
        chk("empty1", empty1, int'(n == 0));
        chk("full0", full0, int'(n == DEPTH));
        chk("full1", full1, int'(n == DEPTH));
        chk("afull0", af0, int'(n >= AF));
        chk("afull1", af1, int'(n >= AF));
        chk("aempty0", ae0, int'(n <= AE));
        chk("aempty1", ae1, int'(n <= AE));
        chk("ovf0", ovf0, m_ovf);
        chk("ovf1", ovf1, m_ovf);
        chk("udf0", udf0, m_udf);
        chk("udf1", udf1, m_udf);
        chk("out_reg", out0, last_pop);
        chk("out_fwft", out1, head);
    endtask

    task automatic step(input logic w, input logic r, input logic c,
                        input logic [DW-1:0] d);
        int n;
        @(negedge clk);
        rst     = 1'b0;
        wr_en   = w;
        rd_en   = r;
        clr_err = c;
        buf_in  = d;
        n = mq.size();
        if (r && n != 0) begin
            last_pop = mq.pop_front();
            exp_q.push_back(last_pop);
        end
        if (w && n != DEPTH) mq.push_back(d);
        m_ovf = (m_ovf && !c) || (w && n == DEPTH);
        m_udf = (m_udf && !c) || (r && n == 0);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        mq.delete();
        last_pop = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Monitor: every accepted read on the registered instance must
    // present the next scoreboard word right after the edge.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            if (!rst && rd_en && !empty0) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underrun: read 0x%0h, nothing expected",
                             out0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_rdata", out0, e);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        buf_in   = '0;
        last_pop = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;

        do_reset();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h20 + i));
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        step(1'b1, 1'b1, 1'b0, 8'hEF);
        step(1'b1, 1'b0, 1'b0, 8'h77);
        step(1'b1, 1'b0, 1'b1, 8'h78);
        while (mq.size() != 0) step(1'b0, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'(i));
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);

        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom));
        do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00);

        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            int pr;
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 249) == 0) do_reset();
                step($urandom_range(0, 99) < pw,
                     $urandom_range(0, 99) < pr,
                     $urandom_range(0, 15) == 0,
                     DW'($urandom));
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
